// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM states, TX fill modes and the latched burst config.
// Config fields are sized for the largest supported instance (CS_W <= 8, ADDR_W <= 16).
package spi_pkg;
  localparam int CS_W_MAX   = 8;
  localparam int ADDR_W_MAX = 16;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_e;

  typedef enum logic [1:0] {
    TX_DATA  = 2'b00,
    TX_ONES  = 2'b01,
    TX_ZEROS = 2'b10,
    TX_DATA2 = 2'b11
  } tx_mode_e;

  typedef struct packed {
    logic                  cpol;
    logic                  cpha;
    logic [CS_W_MAX-1:0]   cs_sel;
    logic [ADDR_W_MAX-1:0] n_end;
    tx_mode_e              tx_mode;
  } spi_cfg_t;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: toggles every DIV cycles while enabled, flagging each toggle as lead or trail.
// While disabled the counter is held clear and SCLK parks at cpol.
module spi_sclk_gen #(
  parameter int DIV = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic cpol_i,
  output logic sclk_o,
  output logic lead_o,
  output logic trail_o
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             sclk_q;
  logic             ph_q;
  logic             tick;

  // Pulses coincide with the clock edge on which SCLK flips.
  assign tick    = en_i && (cnt_q == CNT_W'(DIV - 1));
  assign lead_o  = tick && !ph_q;
  assign trail_o = tick && ph_q;
  assign sclk_o  = sclk_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      ph_q   <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      sclk_q <= cpol_i;
      ph_q   <= 1'b0;
    end else if (tick) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
      ph_q   <= ~ph_q;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/spi_master_ctrl_param.sv
// Parametrised SPI master: burst FSM, shift registers and word counter around spi_sclk_gen.
// Words are read from / written to external register files indexed by the word counter.
module spi_master_ctrl_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CS   = 4,
  parameter int DIV    = 50,
  parameter int ADDR_W = 10,
  parameter int CS_W   = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic [ADDR_W-1:0] n_end_i,
  input  logic [1:0]        tx_mode_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [ADDR_W-1:0] tx_addr_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic [ADDR_W-1:0] rx_addr_o,
  output logic              rx_we_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [N_CS-1:0]   cs_n_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q;
  spi_cfg_t          cfg_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic [BIT_W-1:0]  bit_q;
  logic [ADDR_W-1:0] k_q, rx_addr_q;
  logic [N_CS-1:0]   cs_n_q;
  logic              mosi_q, busy_q, done_q, rx_we_q;

  logic              sclk_en, gen_cpol, lead, trail, last_bit;
  logic [DATA_W-1:0] tx_word_d, rx_shift_d;

  function automatic logic [N_CS-1:0] cs_dec(input logic [CS_W_MAX-1:0] sel);
    logic [N_CS-1:0] v;
    v = '1;
    for (int i = 0; i < N_CS; i++)
      if (int'(sel) == i) v[i] = 1'b0;
    return v;
  endfunction

  // Park SCLK at the incoming cpol on the start edge so LOAD already shows the new idle level.
  assign sclk_en    = (state_q == SHIFT);
  assign gen_cpol   = (state_q == IDLE && start_i) ? cpol_i : cfg_q.cpol;
  assign rx_shift_d = {rx_sh_q[DATA_W-2:0], miso_i};
  assign last_bit   = (bit_q == BIT_W'(DATA_W - 1));

  always_comb begin
    tx_word_d = tx_data_i;
    case (cfg_q.tx_mode)
      TX_ONES:  tx_word_d = '1;
      TX_ZEROS: tx_word_d = '0;
      default:  tx_word_d = tx_data_i;
    endcase
  end

  spi_sclk_gen #(.DIV(DIV)) u_sclk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (sclk_en),
    .cpol_i  (gen_cpol),
    .sclk_o  (sclk_o),
    .lead_o  (lead),
    .trail_o (trail)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      k_q       <= '0;
      rx_addr_q <= '0;
      cs_n_q    <= '1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_we_q   <= 1'b0;
    end else begin
      rx_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          cfg_q.cpol    <= cpol_i;
          cfg_q.cpha    <= cpha_i;
          cfg_q.cs_sel  <= CS_W_MAX'(cs_sel_i);
          cfg_q.n_end   <= ADDR_W_MAX'(n_end_i);
          cfg_q.tx_mode <= tx_mode_e'(tx_mode_i);
          cs_n_q        <= cs_dec(CS_W_MAX'(cs_sel_i));
          k_q           <= '0;
          busy_q        <= 1'b1;
          state_q       <= LOAD;
        end
        LOAD: begin
          cs_n_q  <= cs_dec(cfg_q.cs_sel);
          tx_sh_q <= tx_word_d;
          bit_q   <= '0;
          if (!cfg_q.cpha) mosi_q <= tx_word_d[DATA_W-1];
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (lead) begin
            if (cfg_q.cpha) begin
              mosi_q  <= tx_sh_q[DATA_W-1];
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
            end else begin
              rx_sh_q <= rx_shift_d;
            end
          end
          if (trail) begin
            if (cfg_q.cpha) begin
              rx_sh_q <= rx_shift_d;
            end else begin
              mosi_q  <= tx_sh_q[DATA_W-2];
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
            end
            bit_q <= bit_q + BIT_W'(1);
            // With CPHA=1 the final bit is sampled on this very edge.
            if (last_bit) begin
              rx_data_q <= cfg_q.cpha ? rx_shift_d : rx_sh_q;
              rx_addr_q <= k_q;
              rx_we_q   <= 1'b1;
              state_q   <= STORE;
            end
          end
        end
        STORE: begin
          if (ADDR_W_MAX'(k_q) == cfg_q.n_end) begin
            done_q  <= 1'b1;
            cs_n_q  <= '1;
            state_q <= DONE;
          end else begin
            k_q     <= k_q + ADDR_W'(1);
            state_q <= LOAD;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_addr_o = k_q;
  assign rx_data_o = rx_data_q;
  assign rx_addr_o = rx_addr_q;
  assign rx_we_o   = rx_we_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
endmodule

// File: doc/spi_master_ctrl_param.md
Name: spi_master_ctrl_param

Overview:
Parametrised SPI master controller. It is the successor to the fixed-mode SPI FSM plus external clock-divider pair.
- Integrates SCLK generation.
- Supports all four CPOL/CPHA modes, configurable word width and N_CS chip selects.
- Runs multi-word bursts against external TX/RX register-file ports.
- Sits between the control-register block and the SPI pins.

Parameters:
DATA_W, 8, bits per SPI word, shifted MSB first
N_CS, 4, number of active-low chip-select outputs
DIV, 50, system clocks per SCLK half-period (10 MHz to 100 kHz); minimum 2
ADDR_W, 10, TX/RX register-file address width; burst length up to 2^ADDR_W words
CS_W, $clog2(N_CS) (min 1), width of chip-select index

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-low
start_i  in  1  begin burst; sampled only in IDLE
cpol_i  in  1  SCLK idle level; latched at start
cpha_i  in  1  0: sample on leading edge, 1: sample on trailing edge; latched at start
cs_sel_i  in  CS_W  target slave index; latched at start
n_end_i  in  ADDR_W  index of last word (burst = n_end_i+1 words); latched at start
tx_mode_i  in  2  00 data, 01 all ones, 10 all zeros, 11 same as 00; latched at start
tx_data_i  in  DATA_W  TX word at tx_addr_o, combinational read
tx_addr_o  out  ADDR_W  TX read address = current word index
rx_data_o  out  DATA_W  received word
rx_addr_o  out  ADDR_W  RX write address = current word index
rx_we_o  out  1  one-cycle RX write strobe
sclk_o  out  1  SPI clock
mosi_o  out  1  SPI data out
miso_i  in  1  SPI data in
cs_n_o  out  N_CS  chip selects, active-low, one-hot-low when active
busy_o  out  1  high from LOAD through DONE
done_o  out  1  one-cycle pulse at burst end

Behaviour:
Reset (rst_i=0 at a rising edge), effective the next cycle:
- State IDLE; sclk_o=0; mosi_o=0; cs_n_o all 1.
- busy_o=0, done_o=0, rx_we_o=0; tx_addr_o, rx_addr_o, rx_data_o all 0.
- Latched cpol is cleared to 0.
- Reset mid-transfer aborts immediately. No partial RX write occurs.

State IDLE:
- sclk_o = latched cpol.
- start_i=1 latches all config inputs, clears the word index k, and goes to LOAD.

State LOAD (1 cycle):
- cs_n_o[cs_sel]=0; busy_o=1.
- Shift register loads tx_data_i, or all ones/all zeros per mode.
- If CPHA=0, mosi_o presents the MSB at the end of LOAD.
- Next state: SHIFT.

State SHIFT:
- The SCLK generator runs. Counter 0..DIV-1 is cleared on entry; SCLK toggles when the counter reaches DIV-1.
- Each toggle produces a lead or trail pulse, alternating, starting with lead. The first edge comes DIV cycles after SHIFT entry.
- CPHA=0: sample miso_i on lead; shift and present the next bit on trail.
- CPHA=1: shift and present the bit on lead (the first lead presents the MSB); sample on trail.
- SHIFT lasts exactly 2*DIV*DATA_W cycles and ends on the DATA_W-th trail edge, with SCLK back at cpol.
- Next state: STORE.

State STORE (1 cycle):
- rx_we_o=1, rx_addr_o=k, rx_data_o = received word.
- If k == n_end, go to DONE. Otherwise k increments and the FSM goes to LOAD; CS stays asserted between words.

State DONE (1 cycle):
- done_o=1; cs_n_o all 1.
- Next state: IDLE. busy_o drops in IDLE.

Timing and boundary rules:
- Word time is 2*DIV*DATA_W + 2 cycles. Burst latency from start is (n_end+1)*(2*DIV*DATA_W + 2) + 1 cycles to done_o.
- start_i while busy, and config input changes while busy, are ignored.
- n_end_i = 2^ADDR_W-1 is a legal maximum; k must not wrap before the comparison.
- cs_sel_i >= N_CS: no CS is asserted, but the transfer still runs.

Decomposition:
Package spi_pkg holds:
- enum state_e {IDLE, LOAD, SHIFT, STORE, DONE}
- enum tx_mode_e
- struct spi_cfg_t (cpol, cpha, cs_sel, n_end, tx_mode)

Sub-module spi_sclk_gen (params DIV):
- Inputs: enable, cpol.
- Outputs: sclk, lead pulse, trail pulse.
- Counter is cleared whenever enable is low.

The top module holds the FSM, shift register and bit/word counters.

Test Plan:
- Bench params DIV=2, DATA_W=8, N_CS=4. Drive start_i, then pull rst_i=0 for 1 cycle mid-SHIFT -> next cycle cs_n_o=4'b1111, sclk_o=0, busy_o=0, no rx_we_o.
- Mode 0, loopback miso_i=mosi_o, tx 8'hA5, n_end=0, cs_sel=0 -> cs_n_o=4'b1110; 8 SCLK pulses; rx_we_o at addr 0 with 8'hA5; done_o 35 cycles after start.
- Mode 3, cs_sel=2, n_end=2, TX 8'h01/8'h80/8'hFF, loopback -> cs_n_o=4'b1011 continuously; sclk idles high; rx_we_o at addrs 0,1,2 with matching data; exactly one done_o.
- tx_mode=01 with tx_data_i=8'h00 and miso_i=0 -> mosi_o constantly 1 during SHIFT; rx 8'h00.
- CPHA=1 edge check -> mosi_o changes only on lead edges and miso_i is sampled on trail edges. Drive miso_i with a pattern that differs between the two edges; expect 8'h3C.
- start_i and cpha_i toggled while busy -> no restart; timing matches the latched mode; a start after done_o begins a new burst.
